// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU.
// Handles MEM/WB forwarding, back-pressure, flush, and a saturating stall counter.
`default_nettype none

module id_ex_stage #(
   parameter int DataSize     = 32,
   parameter int ALUopSize    = 4,
   parameter int RegAddrSize  = 5,
   parameter int StallCntSize = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    id_valid,
   output logic                    id_ready,
   input  logic [ALUopSize-1:0]    id_alu_type,
   input  logic [RegAddrSize-1:0]  id_rs1_addr,
   input  logic [RegAddrSize-1:0]  id_rs2_addr,
   input  logic [DataSize-1:0]     id_rs1_data,
   input  logic [DataSize-1:0]     id_rs2_data,
   input  logic [DataSize-1:0]     id_imm,
   input  logic                    id_use_imm,
   input  logic [RegAddrSize-1:0]  id_rd_addr,
   input  logic                    id_rd_we,
   input  logic                    flush,
   input  logic                    ex_ready,
   input  logic                    mem_fwd_we,
   input  logic [RegAddrSize-1:0]  mem_fwd_addr,
   input  logic [DataSize-1:0]     mem_fwd_data,
   input  logic                    wb_fwd_we,
   input  logic [RegAddrSize-1:0]  wb_fwd_addr,
   input  logic [DataSize-1:0]     wb_fwd_data,
   output logic                    ex_valid,
   output logic [DataSize-1:0]     src1,
   output logic [DataSize-1:0]     src2,
   output logic [ALUopSize-1:0]    alu_type,
   output logic [RegAddrSize-1:0]  ex_rd_addr,
   output logic                    ex_rd_we,
   output logic [StallCntSize-1:0] stall_cnt
);

   localparam logic [ALUopSize-1:0]    c_NDEF     = ALUopSize'(8);
   localparam logic [StallCntSize-1:0] c_CNT_MAX  = {StallCntSize{1'b1}};
   localparam logic [RegAddrSize-1:0]  c_ZERO_REG = '0;

   logic                    r_valid;
   logic [ALUopSize-1:0]    r_alu_type;
   logic [RegAddrSize-1:0]  r_rs1_addr;
   logic [RegAddrSize-1:0]  r_rs2_addr;
   logic [DataSize-1:0]     r_rs1_data;
   logic [DataSize-1:0]     r_rs2_data;
   logic [DataSize-1:0]     r_imm;
   logic                    r_use_imm;
   logic [RegAddrSize-1:0]  r_rd_addr;
   logic                    r_rd_we;
   logic [StallCntSize-1:0] r_stall_cnt;

   logic                    w_id_ready;
   logic                    w_capture;
   logic                    w_hold;
   logic                    w_mem_hit1;
   logic                    w_wb_hit1;
   logic                    w_mem_hit2;
   logic                    w_wb_hit2;
   logic [DataSize-1:0]     w_fwd1;
   logic [DataSize-1:0]     w_fwd2;

   assign w_id_ready = rst & ~flush & (~r_valid | ex_ready);
   assign w_capture  = id_valid & w_id_ready;
   assign w_hold     = r_valid & ~ex_ready;

   // x0 is hardwired, so a writer targeting it never forwards.
   assign w_mem_hit1 = mem_fwd_we & (mem_fwd_addr == r_rs1_addr) & (r_rs1_addr != c_ZERO_REG);
   assign w_wb_hit1  = wb_fwd_we  & (wb_fwd_addr  == r_rs1_addr) & (r_rs1_addr != c_ZERO_REG);
   assign w_mem_hit2 = mem_fwd_we & (mem_fwd_addr == r_rs2_addr) & (r_rs2_addr != c_ZERO_REG);
   assign w_wb_hit2  = wb_fwd_we  & (wb_fwd_addr  == r_rs2_addr) & (r_rs2_addr != c_ZERO_REG);

   always_comb begin
      w_fwd1 = r_rs1_data;
      if (w_mem_hit1) begin
         w_fwd1 = mem_fwd_data;
      end else if (w_wb_hit1) begin
         w_fwd1 = wb_fwd_data;
      end
   end

   always_comb begin
      w_fwd2 = r_rs2_data;
      if (w_mem_hit2) begin
         w_fwd2 = mem_fwd_data;
      end else if (w_wb_hit2) begin
         w_fwd2 = wb_fwd_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_valid     <= 1'b0;
         r_alu_type  <= c_NDEF;
         r_rs1_addr  <= '0;
         r_rs2_addr  <= '0;
         r_rs1_data  <= '0;
         r_rs2_data  <= '0;
         r_imm       <= '0;
         r_use_imm   <= 1'b0;
         r_rd_addr   <= '0;
         r_rd_we     <= 1'b0;
         r_stall_cnt <= '0;
      end else if (flush) begin
         r_valid    <= 1'b0;
         r_alu_type <= c_NDEF;
         r_rd_we    <= 1'b0;
      end else if (w_capture) begin
         r_valid    <= 1'b1;
         r_alu_type <= id_alu_type;
         r_rs1_addr <= id_rs1_addr;
         r_rs2_addr <= id_rs2_addr;
         r_rs1_data <= id_rs1_data;
         r_rs2_data <= id_rs2_data;
         r_imm      <= id_imm;
         r_use_imm  <= id_use_imm;
         r_rd_addr  <= id_rd_addr;
         r_rd_we    <= id_rd_we;
      end else if (w_hold) begin
         // Absorb producers retiring mid-stall so their results are not lost.
         r_rs1_data <= w_fwd1;
         r_rs2_data <= w_fwd2;
         if (r_stall_cnt != c_CNT_MAX) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
         end
      end else if (r_valid) begin
         r_valid    <= 1'b0;
         r_alu_type <= c_NDEF;
      end
   end

   assign id_ready   = w_id_ready;
   assign ex_valid   = r_valid;
   assign src1       = r_valid ? w_fwd1 : '0;
   assign src2       = r_valid ? (r_use_imm ? r_imm : w_fwd2) : '0;
   assign alu_type   = r_valid ? r_alu_type : c_NDEF;
   assign ex_rd_addr = r_rd_addr;
   assign ex_rd_we   = r_rd_we & r_valid;
   assign stall_cnt  = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage.
`default_nettype none

module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid;
   logic        id_ready;
   logic [3:0]  id_alu_type;
   logic [4:0]  id_rs1_addr;
   logic [4:0]  id_rs2_addr;
   logic [31:0] id_rs1_data;
   logic [31:0] id_rs2_data;
   logic [31:0] id_imm;
   logic        id_use_imm;
   logic [4:0]  id_rd_addr;
   logic        id_rd_we;
   logic        flush;
   logic        ex_ready;
   logic        mem_fwd_we;
   logic [4:0]  mem_fwd_addr;
   logic [31:0] mem_fwd_data;
   logic        wb_fwd_we;
   logic [4:0]  wb_fwd_addr;
   logic [31:0] wb_fwd_data;
   logic        ex_valid;
   logic [31:0] src1;
   logic [31:0] src2;
   logic [3:0]  alu_type;
   logic [4:0]  ex_rd_addr;
   logic        ex_rd_we;
   logic [15:0] stall_cnt;

   int checks   = 0;
   int failures = 0;

   id_ex_stage dut (
      .clk          (clk),
      .rst          (rst),
      .id_valid     (id_valid),
      .id_ready     (id_ready),
      .id_alu_type  (id_alu_type),
      .id_rs1_addr  (id_rs1_addr),
      .id_rs2_addr  (id_rs2_addr),
      .id_rs1_data  (id_rs1_data),
      .id_rs2_data  (id_rs2_data),
      .id_imm       (id_imm),
      .id_use_imm   (id_use_imm),
      .id_rd_addr   (id_rd_addr),
      .id_rd_we     (id_rd_we),
      .flush        (flush),
      .ex_ready     (ex_ready),
      .mem_fwd_we   (mem_fwd_we),
      .mem_fwd_addr (mem_fwd_addr),
      .mem_fwd_data (mem_fwd_data),
      .wb_fwd_we    (wb_fwd_we),
      .wb_fwd_addr  (wb_fwd_addr),
      .wb_fwd_data  (wb_fwd_data),
      .ex_valid     (ex_valid),
      .src1         (src1),
      .src2         (src2),
      .alu_type     (alu_type),
      .ex_rd_addr   (ex_rd_addr),
      .ex_rd_we     (ex_rd_we),
      .stall_cnt    (stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_instr(input logic [3:0] op, input logic [4:0] a1, input logic [31:0] d1,
                            input logic [4:0] a2, input logic [31:0] d2, input logic ui,
                            input logic [31:0] im, input logic [4:0] rd, input logic we);
      id_alu_type = op;
      id_rs1_addr = a1;
      id_rs1_data = d1;
      id_rs2_addr = a2;
      id_rs2_data = d2;
      id_use_imm  = ui;
      id_imm      = im;
      id_rd_addr  = rd;
      id_rd_we    = we;
   endtask

   initial begin
      rst = 1'b0; id_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1;
      mem_fwd_we = 1'b0; mem_fwd_addr = '0; mem_fwd_data = '0;
      wb_fwd_we = 1'b0; wb_fwd_addr = '0; wb_fwd_data = '0;
      set_instr(4'd0, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd0, 1'b0);

      // Reset for two cycles
      tick(); tick();
      chk("rst_ex_valid", {31'b0, ex_valid}, 32'd0);
      chk("rst_alu_type", {28'b0, alu_type}, 32'd8);
      chk("rst_src1", src1, 32'h0);
      chk("rst_src2", src2, 32'h0);
      chk("rst_id_ready", {31'b0, id_ready}, 32'd0);
      chk("rst_stall_cnt", {16'b0, stall_cnt}, 32'd0);
      chk("rst_rd_we", {31'b0, ex_rd_we}, 32'd0);
      rst = 1'b1;
      #1;
      chk("rel_id_ready", {31'b0, id_ready}, 32'd1);

      // Basic ADD capture then drain
      set_instr(4'd0, 5'd1, 32'h10, 5'd2, 32'h20, 1'b0, 32'h0, 5'd3, 1'b1);
      id_valid = 1'b1;
      tick();
      id_valid = 1'b0;
      #1;
      chk("add_ex_valid", {31'b0, ex_valid}, 32'd1);
      chk("add_src1", src1, 32'h10);
      chk("add_src2", src2, 32'h20);
      chk("add_alu_type", {28'b0, alu_type}, 32'd0);
      chk("add_rd_addr", {27'b0, ex_rd_addr}, 32'd3);
      chk("add_rd_we", {31'b0, ex_rd_we}, 32'd1);
      tick();
      chk("drain_ex_valid", {31'b0, ex_valid}, 32'd0);
      chk("drain_alu_type", {28'b0, alu_type}, 32'd8);
      chk("drain_src1", src1, 32'h0);
      chk("drain_rd_we", {31'b0, ex_rd_we}, 32'd0);

      // Forward priority: MEM over WB over held
      set_instr(4'd1, 5'd5, 32'h1, 5'd6, 32'h2, 1'b0, 32'h0, 5'd7, 1'b1);
      id_valid = 1'b1;
      tick();
      id_valid = 1'b0;
      chk("fwd_held_src1", src1, 32'h1);
      mem_fwd_we = 1'b1; mem_fwd_addr = 5'd5; mem_fwd_data = 32'hAA;
      wb_fwd_we = 1'b1; wb_fwd_addr = 5'd5; wb_fwd_data = 32'hBB;
      #1;
      chk("fwd_mem_wins", src1, 32'hAA);
      chk("fwd_src2_untouched", src2, 32'h2);
      mem_fwd_we = 1'b0;
      #1;
      chk("fwd_wb_only", src1, 32'hBB);
      wb_fwd_addr = 5'd6;
      #1;
      chk("fwd_wb_rs2", src2, 32'hBB);
      wb_fwd_we = 1'b0;
      tick();

      // x0 never forwards
      set_instr(4'd0, 5'd0, 32'h77, 5'd0, 32'h66, 1'b0, 32'h0, 5'd1, 1'b0);
      id_valid = 1'b1;
      tick();
      id_valid = 1'b0;
      mem_fwd_we = 1'b1; mem_fwd_addr = 5'd0; mem_fwd_data = 32'h99;
      wb_fwd_we = 1'b1; wb_fwd_addr = 5'd0; wb_fwd_data = 32'h88;
      #1;
      chk("x0_src1", src1, 32'h77);
      chk("x0_src2", src2, 32'h66);
      mem_fwd_we = 1'b0; wb_fwd_we = 1'b0;
      tick();

      // Stall with operand refresh from a one-cycle WB pulse
      ex_ready = 1'b0;
      set_instr(4'd0, 5'd1, 32'h11, 5'd7, 32'h22, 1'b0, 32'h0, 5'd9, 1'b1);
      id_valid = 1'b1;
      tick();
      id_valid = 1'b0;
      chk("stall_src2_pre", src2, 32'h22);
      chk("stall_id_ready0", {31'b0, id_ready}, 32'd0);
      wb_fwd_we = 1'b1; wb_fwd_addr = 5'd7; wb_fwd_data = 32'h55;
      tick();
      wb_fwd_we = 1'b0;
      #1;
      chk("stall_src2_c2", src2, 32'h55);
      chk("stall_cnt_c1", {16'b0, stall_cnt}, 32'd1);
      tick();
      chk("stall_src2_c3", src2, 32'h55);
      chk("stall_id_ready1", {31'b0, id_ready}, 32'd0);
      tick();
      chk("stall_cnt_3", {16'b0, stall_cnt}, 32'd3);
      chk("stall_src1", src1, 32'h11);
      chk("stall_id_ready2", {31'b0, id_ready}, 32'd0);

      // Flush beats capture of a new instruction
      set_instr(4'd5, 5'd2, 32'h123, 5'd3, 32'h456, 1'b0, 32'h0, 5'd4, 1'b1);
      id_valid = 1'b1; flush = 1'b1;
      #1;
      chk("flush_id_ready", {31'b0, id_ready}, 32'd0);
      tick();
      flush = 1'b0; id_valid = 1'b0;
      #1;
      chk("flush_ex_valid", {31'b0, ex_valid}, 32'd0);
      chk("flush_rd_we", {31'b0, ex_rd_we}, 32'd0);
      chk("flush_alu_type", {28'b0, alu_type}, 32'd8);
      chk("flush_stall_cnt", {16'b0, stall_cnt}, 32'd3);
      chk("flush_src1", src1, 32'h0);
      tick();
      chk("flush_no_capture", {31'b0, ex_valid}, 32'd0);

      // Immediate is immune to forwarding, including through a stall
      ex_ready = 1'b1;
      set_instr(4'd2, 5'd1, 32'h4, 5'd8, 32'h3, 1'b1, 32'hFFFFFFF0, 5'd10, 1'b1);
      id_valid = 1'b1;
      tick();
      id_valid = 1'b0;
      mem_fwd_we = 1'b1; mem_fwd_addr = 5'd8; mem_fwd_data = 32'hDEAD;
      #1;
      chk("imm_src2", src2, 32'hFFFFFFF0);
      chk("imm_alu_type", {28'b0, alu_type}, 32'd2);
      chk("imm_src1", src1, 32'h4);
      ex_ready = 1'b0;
      tick();
      chk("imm_src2_stalled", src2, 32'hFFFFFFF0);
      chk("imm_stall_cnt", {16'b0, stall_cnt}, 32'd4);
      mem_fwd_we = 1'b0;

      // Reset mid-stall discards the held instruction
      rst = 1'b0;
      tick();
      chk("midrst_ex_valid", {31'b0, ex_valid}, 32'd0);
      chk("midrst_stall_cnt", {16'b0, stall_cnt}, 32'd0);
      chk("midrst_id_ready", {31'b0, id_ready}, 32'd0);
      rst = 1'b1;
      tick();
      chk("midrst_no_replay", {31'b0, ex_valid}, 32'd0);

      // Undefined opcode passes through; counter saturates
      set_instr(4'd9, 5'd1, 32'h1, 5'd2, 32'h2, 1'b0, 32'h0, 5'd1, 1'b0);
      id_valid = 1'b1;
      tick();
      id_valid = 1'b0;
      chk("op9_alu_type", {28'b0, alu_type}, 32'd9);
      repeat (65534) @(posedge clk);
      #1;
      chk("sat_cnt_pre", {16'b0, stall_cnt}, 32'hFFFE);
      tick();
      chk("sat_cnt_max", {16'b0, stall_cnt}, 32'hFFFF);
      tick();
      chk("sat_cnt_hold", {16'b0, stall_cnt}, 32'hFFFF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
